wash_cycle_scheduler: RTL and testbench

Program sequencer for the washing machine: steps a full wash program of fill, detergent, wash, drain, N rinses and spin by driving the machine's valve, motor and lock controls from sensor feedback. Phase durations are measured in prescaled `tick` pulses. Sits between the front panel (start/abort/rinse selection) and the machine actuators/sensors. Handles fill/drain watchdogs, door-open faults and user abort.

---
 rtl/wash_sched_pkg.sv | 31 +++
 rtl/wash_phase_timer.sv | 35 +++
 rtl/wash_cycle_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_wash_cycle_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_sched_pkg.sv
// Shared types for the wash program sequencer.
// Contents:
//   PHASE_W  - width of the externally visible phase code
//   state_e  - sequencer states; the encodings are the phase codes seen
//              on the phase output, so they must not be renumbered
//   is_locked - true in states that keep the door lock engaged and are
//               therefore subject to the door-open fault check
package wash_sched_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [PHASE_W-1:0] {
    S_IDLE  = 4'd0,
    S_FILL  = 4'd1,
    S_SOAP  = 4'd2,
    S_WASH  = 4'd3,
    S_DRAIN = 4'd4,
    S_RINSE = 4'd5,
    S_SPIN  = 4'd6,
    S_DONE  = 4'd7,
    S_FAULT = 4'd8
  } state_e;

  // FILL through SPIN only; FAULT also holds the lock but can never
  // fault again, so it is handled separately by the caller.
  function automatic logic is_locked(input state_e s);
    return (s == S_FILL) || (s == S_SOAP) || (s == S_WASH) ||
           (s == S_DRAIN) || (s == S_RINSE) || (s == S_SPIN);
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable down-counter used for every timed phase and for the
// fill/drain watchdog.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   load          - load load_val this cycle (overrides any decrement)
//   load_val      - value loaded on load
//   tick          - time-base enable; counts down by one when nonzero
//   expire        - combinational: tick present while count is 1, i.e.
//                   this edge consumes the last tick of the phase
module wash_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = tick && (cnt == CNT_W'(1));

endmodule

// File: rtl/wash_cycle_scheduler.sv
// Washing machine program sequencer: fill, detergent, wash, drain,
// N rinses and spin, with door-open fault and user abort.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   tick             - one-cycle time-base enable for phase durations
//   start            - program request (level)
//   door             - 1 = door closed
//   abort            - user abort (level)
//   rinse_cnt        - number of rinses, latched when the program starts
//   filled, drained  - water level sensors
//   detergent_added  - detergent dispense acknowledge
//   lock, water_valve, soap_req, motor, drain_valve, spin - actuators
//   done, fault      - status
//   phase            - current state code
// Build option: define WASH_WATCHDOG_EN to time out FILL and DRAIN after
// FILL_LIMIT ticks without the sensor and enter FAULT.
//
// state | meaning
// IDLE  | waiting for start with door closed
// FILL  | water valve open until filled
// SOAP  | requesting detergent until acknowledged
// WASH  | agitating for WASH_TICKS
// DRAIN | draining until drained; decides rinse / spin / done
// RINSE | agitating for RINSE_TICKS
// SPIN  | high-speed spin with drain for SPIN_TICKS
// DONE  | program complete, door unlocked, waits for start release
// FAULT | door opened while locked or watchdog; drains, exit by reset
module wash_cycle_scheduler
  import wash_sched_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int WASH_TICKS  = 100,
  parameter int RINSE_TICKS = 50,
  parameter int SPIN_TICKS  = 40,
  parameter int FILL_LIMIT  = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               door,
  input  logic               abort,
  input  logic [1:0]         rinse_cnt,
  input  logic               filled,
  input  logic               drained,
  input  logic               detergent_added,
  output logic               lock,
  output logic               water_valve,
  output logic               soap_req,
  output logic               motor,
  output logic               drain_valve,
  output logic               spin,
  output logic               done,
  output logic               fault,
  output logic [PHASE_W-1:0] phase
);

`ifdef WASH_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  state_e     state, state_next;
  logic [1:0] rinses_left, rinses_next;
  logic       rinse_flag, rflag_next;
  logic       abort_flag, aflag_next;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_tick;
  logic             expire;

  // The timer only runs in states that actually use it, so a leftover
  // count from an aborted phase never produces a stray expire.
  function automatic logic is_timed(input state_e s);
    return (s == S_WASH) || (s == S_RINSE) || (s == S_SPIN) ||
           (WD_EN && ((s == S_FILL) || (s == S_DRAIN)));
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rinses_left <= 2'd0;
      rinse_flag  <= 1'b0;
      abort_flag  <= 1'b0;
    end else begin
      state       <= state_next;
      rinses_left <= rinses_next;
      rinse_flag  <= rflag_next;
      abort_flag  <= aflag_next;
    end
  end

  always_comb begin
    state_next  = state;
    rinses_next = rinses_left;
    rflag_next  = rinse_flag;
    aflag_next  = abort_flag;
    if (is_locked(state) && !door) begin
      state_next = S_FAULT;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && door) begin
            state_next  = S_FILL;
            rinses_next = rinse_cnt;
            rflag_next  = 1'b0;
            aflag_next  = 1'b0;
          end
        end
        S_FILL: begin
          if (abort) begin
            state_next = S_DRAIN;
            aflag_next = 1'b1;
          end else if (filled) begin
            state_next = rinse_flag ? S_RINSE : S_SOAP;
          end else if (WD_EN && expire) begin
            state_next = S_FAULT;
          end
        end
        S_SOAP: begin
          if (abort) begin
            state_next = S_DRAIN;
            aflag_next = 1'b1;
          end else if (detergent_added) begin
            state_next = S_WASH;
          end
        end
        S_WASH, S_RINSE: begin
          if (abort) begin
            state_next = S_DRAIN;
            aflag_next = 1'b1;
          end else if (expire) begin
            state_next = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Abort while draining only marks the program for early finish;
          // an abort arriving on the drained edge counts immediately.
          if (abort) begin
            aflag_next = 1'b1;
          end
          if (drained) begin
            if (abort_flag || abort) begin
              state_next = S_DONE;
            end else if (rinses_left != 2'd0) begin
              rinses_next = rinses_left - 2'd1;
              rflag_next  = 1'b1;
              state_next  = S_FILL;
            end else begin
              state_next = S_SPIN;
            end
          end else if (WD_EN && expire) begin
            state_next = S_FAULT;
          end
        end
        S_SPIN: begin
          if (abort) begin
            state_next = S_DRAIN;
            aflag_next = 1'b1;
          end else if (expire) begin
            state_next = S_DONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            state_next = S_IDLE;
          end
        end
        S_FAULT: begin
          state_next = S_FAULT;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tmr_load     = (state_next != state) && is_timed(state_next);
    tmr_load_val = '0;
    case (state_next)
      S_WASH:           tmr_load_val = CNT_W'(WASH_TICKS);
      S_RINSE:          tmr_load_val = CNT_W'(RINSE_TICKS);
      S_SPIN:           tmr_load_val = CNT_W'(SPIN_TICKS);
      S_FILL, S_DRAIN:  tmr_load_val = CNT_W'(FILL_LIMIT);
      default:          tmr_load_val = '0;
    endcase
  end

  assign tmr_tick = tick && is_timed(state);

  wash_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tmr_tick),
    .expire   (expire)
  );

  always_comb begin
    lock        = 1'b0;
    water_valve = 1'b0;
    soap_req    = 1'b0;
    motor       = 1'b0;
    drain_valve = 1'b0;
    spin        = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    case (state)
      S_FILL:  begin lock = 1'b1; water_valve = 1'b1; end
      S_SOAP:  begin lock = 1'b1; soap_req = 1'b1; end
      S_WASH:  begin lock = 1'b1; motor = 1'b1; end
      S_RINSE: begin lock = 1'b1; motor = 1'b1; end
      S_DRAIN: begin lock = 1'b1; drain_valve = 1'b1; end
      S_SPIN:  begin lock = 1'b1; motor = 1'b1; spin = 1'b1; drain_valve = 1'b1; end
      S_DONE:  begin done = 1'b1; end
      S_FAULT: begin lock = 1'b1; drain_valve = 1'b1; fault = 1'b1; end
      default: begin end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// Testbench for wash_cycle_scheduler: a per-cycle program model pushes
// expected phase changes (cycle, phase, actuator outputs) into a queue;
// a monitor pops and compares whenever the DUT phase changes.
module tb_wash_cycle_scheduler;

  localparam int WASH_T  = 4;
  localparam int RINSE_T = 2;
  localparam int SPIN_T  = 3;
  localparam int LIMIT   = 5;
`ifdef WASH_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, start = 1'b0, door = 1'b1, abort = 1'b0;
  logic [1:0] rinse_cnt = 2'd0;
  logic       filled = 1'b0, drained = 1'b0, detergent_added = 1'b0;
  logic       lock, water_valve, soap_req, motor, drain_valve, spin, done, fault;
  logic [3:0] phase;
  logic [7:0] outs;

  assign outs = {lock, water_valve, soap_req, motor, drain_valve, spin, done, fault};

  wash_cycle_scheduler #(
    .CNT_W(16), .WASH_TICKS(WASH_T), .RINSE_TICKS(RINSE_T),
    .SPIN_TICKS(SPIN_T), .FILL_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .door(door),
    .abort(abort), .rinse_cnt(rinse_cnt), .filled(filled), .drained(drained),
    .detergent_added(detergent_added), .lock(lock), .water_valve(water_valve),
    .soap_req(soap_req), .motor(motor), .drain_valve(drain_valve), .spin(spin),
    .done(done), .fault(fault), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] ph;
    logic [7:0] o;
  } exp_t;

  exp_t       sb[$];
  int         obs[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] last_phase = 4'd0;

  // Program model: phase number, rinses still owed, flags, ticks remaining.
  int m_phase, m_left, m_rem;
  bit m_rflag, m_aflag;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_outs(input int ph);
    case (ph)
      1:       return 8'b1100_0000;
      2:       return 8'b1010_0000;
      3, 5:    return 8'b1001_0000;
      4:       return 8'b1000_1000;
      6:       return 8'b1001_1100;
      7:       return 8'b0000_0010;
      8:       return 8'b1000_1001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      last_phase = phase;
    end else if (phase != last_phase) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: phase %0d at cycle %0d, none expected", phase, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.ph != phase || e.o != outs) begin
          miscompares++;
          $display("FAIL phase_change: got phase %0d outs %b at cycle %0d, expected phase %0d outs %b at cycle %0d",
                   phase, outs, cyc, e.ph, e.o, e.cyc);
        end
      end
      obs.push_back(int'(phase));
      last_phase = phase;
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missed_change: phase stayed %0d, expected phase %0d at cycle %0d", phase, e.ph, e.cyc);
    end
  end

  task automatic model_step(input bit t, input bit st, input bit dr, input bit ab,
                            input int rc, input bit fl, input bit dn, input bit dt);
    int np;
    exp_t e;
    np = m_phase;
    if (m_phase >= 1 && m_phase <= 6 && !dr) begin
      np = 8;
    end else begin
      case (m_phase)
        0: if (st && dr) begin np = 1; m_left = rc; m_rflag = 0; m_aflag = 0; m_rem = LIMIT; end
        1: begin
          if (ab) begin np = 4; m_aflag = 1; m_rem = LIMIT; end
          else if (fl) begin
            if (m_rflag) begin np = 5; m_rem = RINSE_T; end
            else np = 2;
          end else if (WD && t) begin
            if (m_rem == 1) np = 8;
            else m_rem--;
          end
        end
        2: begin
          if (ab) begin np = 4; m_aflag = 1; m_rem = LIMIT; end
          else if (dt) begin np = 3; m_rem = WASH_T; end
        end
        3, 5, 6: begin
          if (ab) begin np = 4; m_aflag = 1; m_rem = LIMIT; end
          else if (t) begin
            if (m_rem == 1) np = (m_phase == 6) ? 7 : 4;
            else m_rem--;
            if (np == 4) m_rem = LIMIT;
          end
        end
        4: begin
          if (ab) m_aflag = 1;
          if (dn) begin
            if (m_aflag) np = 7;
            else if (m_left > 0) begin m_left--; m_rflag = 1; np = 1; m_rem = LIMIT; end
            else begin np = 6; m_rem = SPIN_T; end
          end else if (WD && t) begin
            if (m_rem == 1) np = 8;
            else m_rem--;
          end
        end
        7: if (!st) np = 0;
        default: np = 8;
      endcase
    end
    if (np != m_phase) begin
      e.cyc = cyc + 1;
      e.ph  = 4'(np);
      e.o   = exp_outs(np);
      sb.push_back(e);
    end
    m_phase = np;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expectations: %0d left, expected 0", sb.size());
    end
    rst = 1'b0;
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_phase", 32'(phase), 32'd0);
    start = 0; abort = 0; tick = 0; door = 1;
    filled = 0; drained = 0; detergent_added = 0; rinse_cnt = 0;
    m_phase = 0; m_left = 0; m_rem = 0; m_rflag = 0; m_aflag = 0;
    sb.delete();
    obs.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // kind: 0 responsive, 1 abort in first rinse, 2 door open in wash,
  // 3 random, 4 fill never arrives, 5 filled on the watchdog edge,
  // 6 responsive but stop early in wash
  task automatic run_prog(input int kind, input int rc, input int ncyc);
    int hold;
    bit aborted;
    bit t, st, dr, ab, fl, dn, dt;
    int r;
    hold = 0;
    aborted = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      t = 1; st = 1; dr = 1; ab = 0; r = rc;
      fl = (m_phase == 1); dn = (m_phase == 4); dt = (m_phase == 2);
      case (kind)
        1: begin ab = (m_phase == 5) && !aborted; if (ab) aborted = 1; end
        2: begin
          dr = (m_phase != 3);
          if (m_phase == 8) begin
            st = 1'($urandom % 2); ab = 1'($urandom % 2); dr = 1'($urandom % 2);
          end
        end
        3: begin
          t  = 1'($urandom % 2);
          st = (m_phase == 7) ? ($urandom % 4 != 0) : ($urandom % 8 != 0);
          dr = ($urandom_range(0, 299) != 0);
          ab = ($urandom_range(0, 149) == 0);
          r  = int'($urandom % 4);
          fl = ($urandom % 4 == 0);
          dn = ($urandom % 4 == 0);
          dt = ($urandom % 3 == 0);
        end
        4: fl = 0;
        5: fl = (m_phase == 1) && (m_rem == 1);
        default: begin end
      endcase
      tick = t; start = st; door = dr; abort = ab; rinse_cnt = 2'(r);
      filled = fl; drained = dn; detergent_added = dt;
      model_step(t, st, dr, ab, r, fl, dn, dt);
      if (kind != 3) begin
        if (kind == 6 ? (m_phase == 3) : (m_phase == 7 || m_phase == 8)) hold++;
        if (hold >= ((kind == 6) ? 2 : 10)) break;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_seq(input string nm, input int n, input int e[9]);
    chk({nm, "_len"}, 32'(obs.size()), 32'(n));
    for (int i = 0; i < n && i < obs.size(); i++) begin
      chk({nm, "_step"}, 32'(obs[i]), 32'(e[i]));
    end
  endtask

  initial begin
    do_reset();

    run_prog(0, 1, 200);
    check_seq("seq_one_rinse", 9, '{1, 2, 3, 4, 1, 5, 4, 6, 7});
    chk("end_done_lock", 32'({done, lock}), 32'b10);
    do_reset();

    run_prog(0, 0, 200);
    check_seq("seq_no_rinse", 6, '{1, 2, 3, 4, 6, 7, 0, 0, 0});
    do_reset();

    run_prog(1, 3, 200);
    check_seq("seq_abort_rinse", 8, '{1, 2, 3, 4, 1, 5, 4, 7, 0});
    do_reset();

    run_prog(2, 2, 200);
    check_seq("seq_door_fault", 4, '{1, 2, 3, 8, 0, 0, 0, 0, 0});
    chk("door_fault_outs", 32'(outs), 32'b1000_1001);
    chk("door_fault_phase", 32'(phase), 32'd8);
    do_reset();

    run_prog(6, 1, 200);
    chk("pre_reset_wash", 32'(phase), 32'd3);
    do_reset();

`ifdef WASH_WATCHDOG_EN
    run_prog(4, 0, 200);
    check_seq("seq_fill_watchdog", 2, '{1, 8, 0, 0, 0, 0, 0, 0, 0});
    chk("watchdog_outs", 32'(outs), 32'b1000_1001);
    do_reset();

    run_prog(5, 0, 200);
    check_seq("seq_fill_on_expiry", 6, '{1, 2, 3, 4, 6, 7, 0, 0, 0});
    do_reset();
`endif

    for (int k = 0; k < 20; k++) begin
      run_prog(3, 0, 400);
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
